// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor
//   Watches a 4-bit up/down counter that runs on the same clock. It reports
//   wraps (15->0 counting up, 0->15 counting down), keeps a saturating wrap
//   count, flags a counter that has stopped moving, and latches an error on
//   any step the counter could not legally have made.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   INIT  | no reference sample yet; the next edge only captures prev
//   TRACK | checking each step against the direction used for it
//   STALL | value unchanged for STALL_LIM or more samples
//   ERR   | illegal step seen; absorbing until clr or reset
//
// Ports
//   clk       rising-edge clock, shared with the monitored counter
//   reset     asynchronous active-low reset
//   cout_in   counter value being monitored
//   load_in   counter load strobe (a parallel load happens at this edge)
//   mode_in   counter direction applied at this edge (0 up, 1 down)
//   clr       synchronous clear of all monitor state
//   wrap_up   one-cycle pulse after a legal 15->0 up-step
//   wrap_dn   one-cycle pulse after a legal 0->15 down-step
//   wrap_cnt  saturating count of wraps
//   stall     counter has held its value for STALL_LIM or more samples
//   err       sticky illegal-step flag
//   state     FSM encoding (INIT=0, TRACK=1, STALL=2, ERR=3)
module count_wrap_monitor #(
   parameter int unsigned STALL_LIM = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cout_in,
   input  logic       load_in,
   input  logic       mode_in,
   input  logic       clr,
   output logic       wrap_up,
   output logic       wrap_dn,
   output logic [7:0] wrap_cnt,
   output logic       stall,
   output logic       err,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_TRACK = 2'd1,
      S_STALL = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   localparam logic [3:0] LIM = 4'(STALL_LIM);

   state_t     st_q, st_d;
   logic [3:0] prev_q;
   logic       load_q;
   logic       mode_q;
   logic [3:0] run_q, run_d;
   logic       up_d, dn_d, stall_d, err_d;
   logic [7:0] cnt_d;

   logic [3:0] step;
   logic [3:0] run_inc;
   logic       legal_up, legal_dn;

   // Step is taken mod 16, so a wrap looks exactly like a +/-1 step.
   assign step     = cout_in - prev_q;
   assign run_inc  = (run_q == 4'hF) ? 4'hF : run_q + 4'd1;
   assign legal_up = (step == 4'd1) && !mode_q;
   assign legal_dn = (step == 4'hF) &&  mode_q;

   always_comb begin
      st_d    = st_q;
      run_d   = run_q;
      up_d    = 1'b0;
      dn_d    = 1'b0;
      cnt_d   = wrap_cnt;
      stall_d = stall;
      err_d   = err;

      if (clr) begin
         st_d    = S_INIT;
         run_d   = 4'd0;
         cnt_d   = 8'd0;
         stall_d = 1'b0;
         err_d   = 1'b0;
      end else begin
         case (st_q)
            S_INIT: begin
               st_d    = S_TRACK;
               run_d   = 4'd0;
               stall_d = 1'b0;
            end
            S_TRACK, S_STALL: begin
               if (load_q) begin
                  // A parallel load can jump anywhere; restart the hold run.
                  st_d    = S_TRACK;
                  run_d   = 4'd0;
                  stall_d = 1'b0;
               end else if (step == 4'd0) begin
                  run_d = run_inc;
                  if (run_inc >= LIM) begin
                     st_d    = S_STALL;
                     stall_d = 1'b1;
                  end
               end else if (legal_up || legal_dn) begin
                  st_d    = S_TRACK;
                  run_d   = 4'd0;
                  stall_d = 1'b0;
                  up_d    = legal_up && (prev_q == 4'hF);
                  dn_d    = legal_dn && (prev_q == 4'h0);
                  if ((up_d || dn_d) && (wrap_cnt != 8'hFF))
                     cnt_d = wrap_cnt + 8'd1;
               end else begin
                  st_d    = S_ERR;
                  run_d   = 4'd0;
                  stall_d = 1'b0;
                  err_d   = 1'b1;
               end
            end
            S_ERR: begin
               st_d = S_ERR;
            end
            default: begin
               st_d = S_INIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q     <= S_INIT;
         prev_q   <= 4'd0;
         load_q   <= 1'b0;
         mode_q   <= 1'b0;
         run_q    <= 4'd0;
         wrap_up  <= 1'b0;
         wrap_dn  <= 1'b0;
         wrap_cnt <= 8'd0;
         stall    <= 1'b0;
         err      <= 1'b0;
      end else begin
         st_q     <= st_d;
         prev_q   <= cout_in;
         load_q   <= load_in;
         mode_q   <= mode_in;
         run_q    <= run_d;
         wrap_up  <= up_d;
         wrap_dn  <= dn_d;
         wrap_cnt <= cnt_d;
         stall    <= stall_d;
         err      <= err_d;
      end
   end

   assign state = st_q;

endmodule

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter STALL_LIM, default 8, legal 1..15: consecutive unchanged samples before stall is flagged.
REQ-002 clk  input  1  rising-edge clock, shared with the upstream 4-bit up/down counter.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cout_in  input  4  counter output value being monitored.
REQ-005 load_in  input  1  the counter's load strobe; high means a parallel load occurs at this edge.
REQ-006 mode_in  input  1  the counter's direction (0 = up, 1 = down), as applied at this edge.
REQ-007 clr  input  1  synchronous clear of all monitor state.
REQ-008 wrap_up  output  1  one-cycle pulse on a 15->0 transition.
REQ-009 wrap_dn  output  1  one-cycle pulse on a 0->15 transition.
REQ-010 wrap_cnt  output  8  saturating count of all wraps.
REQ-011 stall  output  1  counter has held its value for STALL_LIM or more samples.
REQ-012 err  output  1  sticky illegal-step flag.
REQ-013 state  output  2  FSM state encoding: INIT=0, TRACK=1, STALL=2, ERR=3.

Function
REQ-014 All outputs shall be registered, and all state shall update only on the rising edge of clk, except for reset.
REQ-015 At each edge the block shall capture cout_in into prev, and load_in and mode_in into load_q and mode_q.
REQ-016 At edge k the step shall be evaluated as d = cout_in - prev mod 16, using prev, load_q and mode_q captured at edge k-1.
REQ-017 From INIT, the first edge shall load prev and enter TRACK, with no step evaluation, no pulse and no error.
REQ-018 If load_q=1, the step evaluation shall be skipped: no pulse, no error, stall run count reset to 0.
REQ-019 In TRACK or STALL, an edge with d=0 shall increment the 4-bit run count, which saturates at 15.
REQ-020 When the run count reaches STALL_LIM, the FSM shall go TRACK->STALL and stall shall be 1 from the next cycle.
REQ-021 d=+1 with mode_q=0 shall be a legal up-step: run count cleared, and STALL->TRACK.
REQ-022 d=-1 with mode_q=1 shall be a legal down-step: run count cleared, and STALL->TRACK.
REQ-023 A legal up-step with prev=15 and cout_in=0 shall pulse wrap_up for exactly one cycle.
REQ-024 A legal down-step with prev=0 and cout_in=15 shall pulse wrap_dn for exactly one cycle.
REQ-025 Each wrap pulse shall increment wrap_cnt by 1, saturating at 255 with no rollover.
REQ-026 Any other non-skipped step shall be illegal, including a step direction contradicting mode_q.
REQ-027 An illegal step shall send the FSM to ERR, set err=1, clear stall, and produce no pulse.
REQ-028 ERR shall be absorbing: err stays 1, wrap_cnt freezes, and no pulses are produced until clr or reset.
REQ-029 clr=1 shall take priority over all step evaluation.
REQ-030 On the next edge after clr=1: wrap_cnt=0, err=0, stall=0, pulses 0, run count 0, state INIT.
REQ-031 wrap_up and wrap_dn shall never be high in the same cycle.

Reset
REQ-032 reset=0 shall immediately force state=INIT, prev=0, load_q=0, mode_q=0, run count 0, and all outputs 0.
REQ-033 Deasserting reset shall be synchronous to clk.
REQ-034 The first edge after reset deassertion shall behave as INIT (REQ-017).
REQ-035 reset asserted mid-operation, including in STALL or ERR, shall discard all history.

Verification
REQ-036 Up-wrap: counter up from 13, mode=0 -> wrap_up one cycle after the edge sampling 0, wrap_cnt=1, err=0.
REQ-037 Down-wrap: load 2, then mode=1, count 2,1,0,15 -> no pulse on the load edge, wrap_dn once, wrap_cnt increments.
REQ-038 Load jump: cout_in goes 5 then 11 with load_q=1 -> err=0, no pulse, state TRACK.
REQ-039 Illegal step: cout_in goes 4 then 7 without load -> err=1 and state=ERR next cycle; later 15->0 steps produce no pulse until clr; after clr, state=INIT and wrap_cnt=0.
REQ-040 Stall: STALL_LIM=8, cout_in held at 6 -> stall=1 after the 8th repeat sample; a step to 7 with mode=0 clears stall and returns to TRACK.
REQ-041 Saturation and reset: 300 up-wraps -> wrap_cnt=255; reset pulsed low mid-cycle -> all outputs 0 immediately.
